// File: rtl/twiddle_seq.sv
// twiddle_seq: stage-aware multi-lane twiddle coefficient sequencer, valid/ready output.
// Optional conjugation with saturation is built when TWIDDLE_CONJ_EN is defined.
`default_nettype none
`timescale 1ns/1ps

module twiddle_seq #(
  parameter int NBITS = 8,
  parameter int N     = 8,
  parameter int LANES = 2,
  localparam int LOG2N = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*NBITS-1:0]         coeff_table,
  input  logic                       start,
  input  logic [LOG2N-1:0]           stage,
  input  logic                       inv,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [LANES*2*NBITS-1:0]   coeff_out,
  output logic                       out_last,
  output logic                       busy
);

  localparam int BEATS = N / (2 * LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = 2 * NBITS;
  localparam int OW    = LANES * LW;

  localparam logic [LOG2N-1:0] EMASK     = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] SMAX      = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     beat_q;
  logic [LOG2N-1:0]  stage_q;
  logic              out_valid_q;
  logic [OW-1:0]     coeff_q;
  logic              out_last_q;
  logic              busy_q;

  logic [CW-1:0]     beat_d;
  logic [LOG2N-1:0]  stage_sel;
  logic [LOG2N-1:0]  stage_clamped;
  logic [OW-1:0]     coeff_d;
  logic              last_d;

  logic [LOG2N-1:0]  lane_j;
  logic [LOG2N-1:0]  lane_e;
  logic [LW-1:0]     lane_ent;
  logic [NBITS-1:0]  lane_re;
  logic [NBITS-1:0]  lane_im;

  // Upper half padded so the table index width equals LOG2N.
  logic [LW-1:0] tab [N];

  for (genvar k = 0; k < N; k++) begin : g_tab
    if (k < N / 2) begin : g_entry
      assign tab[k] = coeff_table[(N/2-k)*LW-1 -: LW];
    end else begin : g_pad
      assign tab[k] = '0;
    end
  end

  assign stage_clamped = (stage > SMAX) ? SMAX : stage;

`ifdef TWIDDLE_CONJ_EN
  localparam logic [NBITS-1:0] IM_MIN = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] IM_MAX = ~IM_MIN;

  logic inv_q;
  logic inv_sel;

  assign inv_sel = (state_q == RUN) ? inv_q : inv;
`else
  logic unused_inv;

  assign unused_inv = inv;
`endif

  always_comb begin
    beat_d    = '0;
    stage_sel = stage_clamped;
    if (state_q == RUN) begin
      beat_d    = beat_q + 1'b1;
      stage_sel = stage_q;
    end
  end

  assign last_d = (beat_d == LAST_BEAT);

  // (j mod 2^s) << (LOG2N-1-s) equals (j << (LOG2N-1-s)) kept to LOG2N-1 bits.
  always_comb begin
    coeff_d  = '0;
    lane_j   = '0;
    lane_e   = '0;
    lane_ent = '0;
    lane_re  = '0;
    lane_im  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_j   = LOG2N'(int'(beat_d) * LANES + l);
      lane_e   = (lane_j << (SMAX - stage_sel)) & EMASK;
      lane_ent = tab[lane_e];
      lane_re  = lane_ent[LW-1 -: NBITS];
      lane_im  = lane_ent[NBITS-1:0];
`ifdef TWIDDLE_CONJ_EN
      if (inv_sel) begin
        lane_im = (lane_im == IM_MIN) ? IM_MAX : -lane_im;
      end
`endif
      coeff_d[(LANES-1-l)*LW +: LW] = {lane_re, lane_im};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      coeff_q     <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TWIDDLE_CONJ_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            stage_q     <= stage_clamped;
            beat_q      <= '0;
            coeff_q     <= coeff_d;
            out_valid_q <= 1'b1;
            out_last_q  <= last_d;
`ifdef TWIDDLE_CONJ_EN
            inv_q       <= inv;
`endif
          end
        end
        RUN: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              beat_q     <= beat_d;
              coeff_q    <= coeff_d;
              out_last_q <= last_d;
            end
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign coeff_out = coeff_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_seq.sv
// tb_twiddle_seq: randomized scoreboard bench for twiddle_seq against an arithmetic reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_twiddle_seq;
  localparam int NBITS = 8;
  localparam int N     = 8;
  localparam int LANES = 2;
  localparam int LOG2N = $clog2(N);
  localparam int BEATS = N / (2 * LANES);
  localparam int OW    = LANES * 2 * NBITS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic inv = 1'b0;
  logic out_ready = 1'b0;
  logic [LOG2N-1:0] stage = '0;
  logic [N*NBITS-1:0] coeff_table = '0;
  logic out_valid, out_last, busy;
  logic [OW-1:0] coeff_out;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int tab_re[N/2];
  int tab_im[N/2];
  int ready_mode = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  twiddle_seq #(.NBITS(NBITS), .N(N), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .coeff_table(coeff_table),
    .start      (start),
    .stage      (stage),
    .inv        (inv),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .coeff_out  (coeff_out),
    .out_last   (out_last),
    .busy       (busy)
  );

  function automatic logic [OW-1:0] model_beat(int st, bit iv, int b);
    logic [OW-1:0] r;
    int s, j, e, re, im;
    bit conj;
    r = '0;
    s = (st > LOG2N - 1) ? LOG2N - 1 : st;
`ifdef TWIDDLE_CONJ_EN
    conj = iv;
`else
    conj = iv & 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
      j  = b * LANES + l;
      e  = (j % (1 << s)) * (1 << (LOG2N - 1 - s));
      re = tab_re[e];
      im = tab_im[e];
      if (conj) begin
        im = -im;
        if (im > (1 << (NBITS - 1)) - 1) im = (1 << (NBITS - 1)) - 1;
      end
      r[(LANES-1-l)*2*NBITS +: 2*NBITS] = {NBITS'(re), NBITS'(im)};
    end
    return r;
  endfunction

  task automatic load_table();
    for (int k = 0; k < N / 2; k++)
      coeff_table[(N/2-k)*2*NBITS-1 -: 2*NBITS] = {NBITS'(tab_re[k]), NBITS'(tab_im[k])};
  endtask

  task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Ready pattern: 0 = always high, 1 = random, 2 = low for the first 3 cycles of beat 0.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        out_ready = (stall_cnt >= 4);
        stall_cnt++;
      end
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst && out_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: actual coeff=%h last=%b, required no beat", coeff_out, out_last);
      end else begin
        if (coeff_out !== exp_q[0].data || out_last !== exp_q[0].last) begin
          fails++;
          $display("FAIL beat: actual coeff=%h last=%b required coeff=%h last=%b",
                   coeff_out, out_last, exp_q[0].data, exp_q[0].last);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Entered and left at posedge+1; the next run may start in the very cycle this one returns.
  task automatic run_one(int st, bit iv, int mode, bit pulse);
    int cnt;
    ready_mode = mode;
    stall_cnt  = 0;
    start = 1'b1;
    stage = LOG2N'(st);
    inv   = iv;
    for (int b = 0; b < BEATS; b++)
      exp_q.push_back('{data: model_beat(st, iv, b), last: (b == BEATS - 1)});
    cnt = 0;
    forever begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 1) begin
        check("start_valid", OW'(out_valid), OW'(1));
        check("start_busy", OW'(busy), OW'(1));
        start = pulse;
        stage = '0;
        inv   = ~iv;
      end else begin
        start = 1'b0;
      end
      if (exp_q.size() == 0) break;
      if (cnt > 300) begin
        tests++;
        fails++;
        $display("FAIL run_timeout: actual %0d beats outstanding, required 0", exp_q.size());
        exp_q.delete();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (mode == 0) check("run_latency", OW'(cnt), OW'(BEATS + 1));
    check("end_valid", OW'(out_valid), OW'(0));
    check("end_busy", OW'(busy), OW'(0));
    check("end_last", OW'(out_last), OW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tab_re = '{127, 90, 0, -90};
    tab_im = '{0, -90, -128, -90};
    load_table();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", OW'(out_valid), OW'(0));
    check("reset_busy", OW'(busy), OW'(0));
    check("reset_last", OW'(out_last), OW'(0));
    check("reset_coeff", coeff_out, OW'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_one(0, 1'b0, 0, 1'b0);
    run_one(2, 1'b0, 0, 1'b0);
    run_one(1, 1'b0, 0, 1'b0);
    run_one(2, 1'b1, 0, 1'b0);
    run_one(2, 1'b0, 2, 1'b0);
    run_one(3, 1'b0, 0, 1'b1);

    // Abort a stage-2 run while beat 1 is presented.
    ready_mode = 0;
    start = 1'b1;
    stage = LOG2N'(2);
    inv   = 1'b0;
    for (int b = 0; b < BEATS; b++)
      exp_q.push_back('{data: model_beat(2, 1'b0, b), last: (b == BEATS - 1)});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("stage2_beat0_literal", coeff_out, 32'h7F00_5AA6);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_valid", OW'(out_valid), OW'(0));
    check("abort_busy", OW'(busy), OW'(0));
    check("abort_coeff", coeff_out, OW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_abort_idle", OW'(out_valid), OW'(0));
    end
    @(posedge clk);
    #1;

    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 0) begin
        for (int k = 0; k < N / 2; k++) begin
          tab_re[k] = int'($urandom_range(0, 255)) - 128;
          tab_im[k] = int'($urandom_range(0, 255)) - 128;
          if ($urandom_range(0, 3) == 0) tab_im[k] = -128;
        end
        load_table();
      end
      run_one(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", OW'(exp_q.size()), OW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/twiddle_seq.md
# twiddle_seq

Parametrised twiddle-factor sequencer for the parallel radix-2 FFT datapath. Replaces the free-running single-coefficient ROM stepper with a stage-aware, multi-lane generator. For a requested stage it emits the exact twiddle exponents each butterfly needs, LANES complex coefficients per beat, under valid/ready flow control. Optional conjugation is provided for inverse transforms. It sits between the combinational coefficient table and the butterfly array.

## Interface
- NBITS, 8, width of each real/imag component (two's complement)
- N, 8, FFT size; power of two, N >= 2*LANES
- LANES, 2, coefficients per beat; power of two
- LOG2N (localparam), $clog2(N)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- coeff_table  in  N*NBITS  packed table of W_N^k, k=0..N/2-1; entry k at [(N/2-k)*2*NBITS-1 -: 2*NBITS], {re,im}, entry 0 at MSB
- start  in  1  single-cycle request, sampled only in IDLE
- stage  in  LOG2N  stage index s, sampled with start
- inv  in  1  conjugate outputs for this run, sampled with start
- out_ready  in  1  downstream accepts current beat
- out_valid  out  1  coeff_out holds a valid beat
- coeff_out  out  LANES*2*NBITS  lane 0 at MSB, each lane {re,im}
- out_last  out  1  asserted with the final beat of a run
- busy  out  1  run in progress

## Operation
- FSM: IDLE, RUN.
  - IDLE -> RUN on start.
  - RUN -> IDLE when the last beat is accepted (out_valid && out_ready && out_last).
- start is ignored in RUN. stage >= LOG2N is clamped to LOG2N-1.
- A run is N/(2*LANES) beats, indexed by beat counter b.
- Lane l of beat b serves butterfly j = b*LANES + l.
- Exponent: e = (j mod 2^s) << (LOG2N-1-s). Range 0..N/2-1; no wrap beyond table.
- Lane value is table entry e, conjugated when the latched inv is 1.
- Conjugation: im_out = -im with saturation; -(-2^(NBITS-1)) yields 2^(NBITS-1)-1. re is unchanged.
- Beat counter advances only on acceptance. When out_ready is low, coeff_out, out_last and out_valid hold stable.
- Reset values: out_valid=0, coeff_out=0, out_last=0, busy=0, state IDLE, counter 0.
- Reset mid-run aborts the run immediately. No partial beat is emitted after release.

## Timing
- All outputs are registered.
- start in cycle t -> busy=1 and out_valid=1 with beat 0 in cycle t+1.
- With out_ready held high, one beat per cycle. The last beat appears in cycle t+N/(2*LANES).
- After the last beat is accepted, out_valid=0, busy=0 and out_last=0 in the next cycle.
- A start in that same next cycle begins a new run: gap of exactly one idle cycle between runs.
- coeff_table is sampled combinationally when each beat is registered. It must be stable while busy.

## Configuration
- TWIDDLE_CONJ_EN defined: inv is latched at start and the conjugation/saturation path is built.
- TWIDDLE_CONJ_EN undefined: inv is ignored, no negation logic exists, and outputs are always the table values.

## Test plan
Setup: N=8, LANES=2, NBITS=8. Table W0=(127,0), W1=(90,-90), W2=(0,-128), W3=(-90,-90).
- Stage 0, out_ready high -> 2 beats {W0,W0}, {W0,W0}; out_last on beat 2; busy falls 1 cycle later.
- Stage 2 -> beat 0 {W0,W1}, beat 1 {W2,W3}. Stage 1 -> {W0,W2}, {W0,W2}.
- Stage 2, inv=1 with TWIDDLE_CONJ_EN -> {(127,0),(90,90)}, {(0,127) saturated,(-90,90)}. Without the macro, output equals the non-inv run.
- Stage 2, out_ready low for 3 cycles on beat 0 -> beat 0 held unchanged, then beat 1 follows the cycle after acceptance.
- Stage 3 (clamped to 2), start pulsed during RUN -> sequence identical to stage 2, second start ignored.
- rst asserted during beat 1 -> out_valid, busy and coeff_out go 0 asynchronously. After release, no output until a new start.
